spi_master_core: RTL and testbench
==================================

# spi_master_core

Parametrised SPI master engine that replaces the fixed 8-bit, mode-0, single-slave path of the current interface. It serialises host words of configurable width over MOSI and captures MISO. It supports all four CPOL/CPHA modes, a programmable S_CLK divider and up to NUM_CS slave selects. Single-entry TX and RX holding registers with full, busy and overrun status decouple the host from the serial timing.

## Interface
- DATA_W, 8: word width in bits, 4..32.
- DIV_W, 8: width of the divider input.
- NUM_CS, 4: number of chip-select lines, 1..16.
- CS_W, 2: width of CS_SEL, ≥ clog2(NUM_CS), minimum 1.

- CLK  in  1  system clock; every register is clocked on the rising edge.
- CLR  in  1  asynchronous, active-low reset.
- WRITE  in  1  one-cycle pulse that loads INCOMING_DATA into the TX holding register.
- READ  in  1  one-cycle pulse that acknowledges the RX holding register.
- INCOMING_DATA  in  DATA_W  word to transmit.
- OUTCOMING_DATA  out  DATA_W  RX holding register, always driven.
- CPOL  in  1  S_CLK idle level.
- CPHA  in  1  0: sample on leading edge; 1: sample on trailing edge.
- CLK_DIV  in  DIV_W  S_CLK half-period = CLK_DIV+1 CLK cycles.
- CS_SEL  in  CS_W  index of the slave to assert.
- LOOPBACK  in  1  internal loopback request; see Configuration.
- STATUS  out  4  {OVERRUN, RX_FULL, TX_FULL, BUSY}, bit 3 down to bit 0.
- MISO  in  1  serial data from the slave.
- MOSI  out  1  serial data to the slave, MSB first.
- S_CLK  out  1  serial clock.
- CS_N  out  NUM_CS  active-low chip selects.

## Operation
- Reset values: CS_N all 1; MOSI 0; S_CLK 0; STATUS 0; OUTCOMING_DATA 0; state IDLE.
- Reset while CLR is low aborts any transfer immediately and asynchronously. CS_N goes high and the holding registers clear.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP. A divider counter runs from CLK_DIV down to 0; each time it reaches 0 it marks one half-period tick (HPT).
- **IDLE**
  - S_CLK is registered to CPOL.
  - If TX_FULL=1: load the shift register, latch CPOL/CPHA/CLK_DIV/CS_SEL for the whole transfer, clear TX_FULL, and go to SETUP.
  - CS_SEL ≥ NUM_CS selects no line; the transfer still runs with CS_N all 1.
- **SETUP**
  - CS_N[sel]=0 and BUSY=1.
  - CPHA=0: the MSB is already on MOSI.
  - Lasts 1 half-period, then goes to SHIFT.
- **SHIFT**
  - S_CLK toggles on every HPT, for 2·DATA_W edges in total.
  - CPHA=0: MISO is sampled on leading edges; MOSI advances on trailing edges.
  - CPHA=1: MOSI advances on leading edges, including the first bit; MISO is sampled on trailing edges.
  - After the last edge, S_CLK is at CPOL; go to HOLD.
- **HOLD**
  - CS_N stays asserted for 1 half-period.
  - At exit: the received word is written to OUTCOMING_DATA. If RX_FULL was already 1, OVERRUN is set (sticky) and the new word overwrites the old. RX_FULL is then set.
  - Go to GAP.
- **GAP**
  - CS_N all 1 for 1 half-period; then IDLE. BUSY falls on entry to IDLE.
- **TX handshake**
  - WRITE with TX_FULL=0 loads the word and sets TX_FULL.
  - WRITE with TX_FULL=1 is ignored; the register is unchanged.
  - WRITE during BUSY is legal and queues the next word.
- **RX handshake**
  - READ clears RX_FULL and OVERRUN.
  - READ in the same cycle as HOLD exit: the write wins. RX_FULL stays 1 and OVERRUN is not set.
- Changes to CPOL, CPHA, CLK_DIV or CS_SEL during BUSY have no effect until the next IDLE→SETUP.

## Timing
- WRITE sampled at edge n gives TX_FULL=1 after edge n.
- IDLE→SETUP happens at edge n+1, so BUSY and CS_N go active after edge n+1.
- Transfer length with H = CLK_DIV+1: SETUP H + SHIFT 2·DATA_W·H + HOLD H + GAP H = (2·DATA_W+3)·H cycles of BUSY.
- RX_FULL rises at the HOLD→GAP edge, (2·DATA_W+2)·H cycles after SETUP entry.
- Back-to-back transfers: a queued word starts at the IDLE edge after GAP, so there is exactly 1 CLK cycle in IDLE between transfers.
- All outputs are registered.

## Configuration
- SPI_LOOPBACK_EN defined: when LOOPBACK=1, the shift register samples the internal MOSI instead of MISO. Pins are unchanged, so S_CLK, CS_N and MOSI still toggle.
- SPI_LOOPBACK_EN undefined: the LOOPBACK port is present but ignored, and MISO is always sampled.

## Test plan
- **Reset:** CLR=0 mid-SHIFT → CS_N=all 1, STATUS=0, MOSI=0, S_CLK=0 within the same cycle (async).
- **Mode 0, DATA_W=8, CLK_DIV=0, CS_SEL=2:**
  - Stimulus: WRITE 8'hA5, slave returns 8'h3C.
  - Required: MOSI bits 1,0,1,0,0,1,0,1; CS_N=4'b1011; BUSY for 19 cycles; OUTCOMING_DATA=8'h3C; RX_FULL=1.
- **Mode 3, CLK_DIV=3:**
  - S_CLK idles high with half-period 4 cycles.
  - MISO is sampled on rising edges; BUSY lasts 76 cycles.
- **Back-to-back:**
  - Stimulus: WRITE 8'h11 and then WRITE 8'h22 while BUSY; no READ.
  - Required: second transfer starts 1 IDLE cycle after GAP; OVERRUN=1; OUTCOMING_DATA holds the second word.
  - A third WRITE while TX_FULL=1 is dropped.
- **Boundary:** READ coincident with HOLD exit → RX_FULL=1, OVERRUN=0.
- **Loopback (SPI_LOOPBACK_EN, LOOPBACK=1, MISO tied 0):** WRITE 8'h5A → OUTCOMING_DATA=8'h5A.

Source files
------------

// File: rtl/spi_master_core.sv
// SPI master engine: DATA_W-bit words, all four CPOL/CPHA modes, S_CLK divider, NUM_CS selects,
// single-entry TX/RX holding registers. Define SPI_LOOPBACK_EN to let LOOPBACK feed MOSI back to RX.
module spi_master_core #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8,
  parameter int NUM_CS = 4,
  parameter int CS_W   = 2
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              WRITE,
  input  logic              READ,
  input  logic [DATA_W-1:0] INCOMING_DATA,
  output logic [DATA_W-1:0] OUTCOMING_DATA,
  input  logic              CPOL,
  input  logic              CPHA,
  input  logic [DIV_W-1:0]  CLK_DIV,
  input  logic [CS_W-1:0]   CS_SEL,
  input  logic              LOOPBACK,
  output logic [3:0]        STATUS,
  input  logic              MISO,
  output logic              MOSI,
  output logic              S_CLK,
  output logic [NUM_CS-1:0] CS_N
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam int              EDGE_W    = $clog2(2 * DATA_W);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

  logic [2:0]        state;
  logic [DIV_W-1:0]  div_cnt;
  logic [DIV_W-1:0]  div_q;
  logic              cpha_q;
  logic [EDGE_W-1:0] edge_cnt;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] tx_hold;
  logic [DATA_W-1:0] rx_q;
  logic              tx_full;
  logic              rx_full;
  logic              overrun;
  logic              busy;
  logic              mosi_q;
  logic              sclk_q;
  logic [NUM_CS-1:0] cs_n_q;

  logic hpt;
  logic start;
  logic hold_exit;
  logic sample_edge;
  logic rx_bit;

  assign hpt       = (div_cnt == '0);
  assign start     = (state == S_IDLE) && tx_full;
  assign hold_exit = (state == S_HOLD) && hpt;
  // Even edge indices are leading edges; CPHA flips which edge type samples.
  assign sample_edge = ~edge_cnt[0] ^ cpha_q;

`ifdef SPI_LOOPBACK_EN
  assign rx_bit = LOOPBACK ? mosi_q : MISO;
`else
  logic unused_loopback;
  assign unused_loopback = LOOPBACK;
  assign rx_bit = MISO;
`endif

  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] v;
    v = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (int'(sel) == i) v[i] = 1'b0;
    end
    return v;
  endfunction

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // in these blocks sees pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      tx_full <= 1'b0;
      tx_hold <= '0;
    end else if (start) begin
      tx_full <= 1'b0;
    end else if (WRITE && !tx_full) begin
      tx_full <= 1'b1;
      tx_hold <= INCOMING_DATA;
    end
  end

  // A word landing at HOLD exit takes priority over a coincident READ.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      rx_q    <= '0;
      rx_full <= 1'b0;
      overrun <= 1'b0;
    end else if (hold_exit) begin
      rx_q    <= rx_shift;
      rx_full <= 1'b1;
      overrun <= READ ? 1'b0 : (overrun | rx_full);
    end else if (READ) begin
      rx_full <= 1'b0;
      overrun <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state    <= S_IDLE;
      div_cnt  <= '0;
      div_q    <= '0;
      cpha_q   <= 1'b0;
      edge_cnt <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      busy     <= 1'b0;
      mosi_q   <= 1'b0;
      sclk_q   <= 1'b0;
      cs_n_q   <= '1;
    end else begin
      if (state != S_IDLE) begin
        div_cnt <= hpt ? div_q : div_cnt - DIV_W'(1);
      end
      case (state)
        S_IDLE: begin
          sclk_q <= CPOL;
          if (tx_full) begin
            state    <= S_SETUP;
            busy     <= 1'b1;
            cpha_q   <= CPHA;
            div_q    <= CLK_DIV;
            div_cnt  <= CLK_DIV;
            cs_n_q   <= cs_decode(CS_SEL);
            edge_cnt <= '0;
            rx_shift <= '0;
            if (CPHA) begin
              tx_shift <= tx_hold;
            end else begin
              mosi_q   <= tx_hold[DATA_W-1];
              tx_shift <= {tx_hold[DATA_W-2:0], 1'b0};
            end
          end
        end
        S_SETUP: begin
          if (hpt) state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (hpt) begin
            sclk_q   <= ~sclk_q;
            edge_cnt <= edge_cnt + EDGE_W'(1);
            if (sample_edge) begin
              rx_shift <= {rx_shift[DATA_W-2:0], rx_bit};
            end else begin
              mosi_q   <= tx_shift[DATA_W-1];
              tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end
            if (edge_cnt == LAST_EDGE) state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (hpt) begin
            state  <= S_GAP;
            cs_n_q <= '1;
          end
        end
        S_GAP: begin
          if (hpt) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign OUTCOMING_DATA = rx_q;
  assign STATUS         = {overrun, rx_full, tx_full, busy};
  assign MOSI           = mosi_q;
  assign S_CLK          = sclk_q;
  assign CS_N           = cs_n_q;

endmodule

// File: tb/tb_spi_master_core.sv
// Scoreboard bench for spi_master_core: a behavioural SPI slave/monitor checks every completed
// transfer against expectations queued when the word is written.
module tb_spi_master_core;
  localparam int DATA_W = 8;
  localparam int DIV_W  = 8;
  localparam int NUM_CS = 4;
  localparam int CS_W   = 3;
`ifdef SPI_LOOPBACK_EN
  localparam bit LB_BUILD = 1'b1;
`else
  localparam bit LB_BUILD = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              CLR = 1'b0;
  logic              WRITE = 1'b0;
  logic              READ = 1'b0;
  logic [DATA_W-1:0] INCOMING_DATA = '0;
  logic [DATA_W-1:0] OUTCOMING_DATA;
  logic              CPOL = 1'b0;
  logic              CPHA = 1'b0;
  logic [DIV_W-1:0]  CLK_DIV = '0;
  logic [CS_W-1:0]   CS_SEL = '0;
  logic              LOOPBACK = 1'b0;
  logic [3:0]        STATUS;
  logic              MISO = 1'b0;
  logic              MOSI;
  logic              S_CLK;
  logic [NUM_CS-1:0] CS_N;

  spi_master_core #(.DATA_W(DATA_W), .DIV_W(DIV_W), .NUM_CS(NUM_CS), .CS_W(CS_W)) dut (
    .CLK(CLK), .CLR(CLR), .WRITE(WRITE), .READ(READ),
    .INCOMING_DATA(INCOMING_DATA), .OUTCOMING_DATA(OUTCOMING_DATA),
    .CPOL(CPOL), .CPHA(CPHA), .CLK_DIV(CLK_DIV), .CS_SEL(CS_SEL),
    .LOOPBACK(LOOPBACK), .STATUS(STATUS), .MISO(MISO), .MOSI(MOSI),
    .S_CLK(S_CLK), .CS_N(CS_N)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [DATA_W-1:0] tx;
    logic [DATA_W-1:0] slv;
    logic [DATA_W-1:0] rx;
    bit                cpol;
    bit                cpha;
    bit                lb;
    int                h;
    logic [NUM_CS-1:0] cs;
    bit                ovr;
    int                gap;
  } xfer_t;

  xfer_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;
  bit    m_rx_full = 1'b0;

  bit c_cpol, c_cpha, c_lb;
  int c_div, c_sel;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_cfg(input bit cpol, input bit cpha, input int div, input int sel, input bit lb);
    @(negedge CLK);
    c_cpol = cpol; c_cpha = cpha; c_div = div; c_sel = sel; c_lb = lb;
    CPOL = cpol; CPHA = cpha; CLK_DIV = DIV_W'(div); CS_SEL = CS_W'(sel); LOOPBACK = lb;
  endtask

  // Expected outcome of one transfer, derived from the current configuration.
  task automatic push_xfer(input logic [DATA_W-1:0] tx, input logic [DATA_W-1:0] slv,
                           input bit ovr, input int gap);
    xfer_t x;
    x.tx   = tx;
    x.slv  = slv;
    x.lb   = c_lb && LB_BUILD;
    x.rx   = x.lb ? tx : slv;
    x.cpol = c_cpol;
    x.cpha = c_cpha;
    x.h    = c_div + 1;
    x.cs   = '1;
    if (c_sel < NUM_CS) x.cs[c_sel] = 1'b0;
    x.ovr  = ovr;
    x.gap  = gap;
    exp_q.push_back(x);
    m_rx_full = 1'b1;
  endtask

  task automatic do_write(input logic [DATA_W-1:0] d);
    @(negedge CLK);
    INCOMING_DATA = d;
    WRITE = 1'b1;
    @(negedge CLK);
    WRITE = 1'b0;
  endtask

  task automatic do_read();
    @(negedge CLK);
    READ = 1'b1;
    @(negedge CLK);
    READ = 1'b0;
    m_rx_full = 1'b0;
  endtask

  task automatic start_xfer(input logic [DATA_W-1:0] tx, input logic [DATA_W-1:0] slv, input int gap);
    push_xfer(tx, slv, m_rx_full, gap);
    do_write(tx);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!(STATUS[0] == 1'b0 && STATUS[1] == 1'b0) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check("transfer completes in budget", 32'(n < budget), 32'd1);
  endtask

  // Behavioural slave + monitor: drives MISO per mode, captures MOSI, times the frame.
  initial begin : monitor
    logic              pb, ps, leading;
    int                busy_cnt, idle_cnt, edges, last_edge, hmin, hmax;
    logic [DATA_W-1:0] sl_tx, sl_rx;
    logic [NUM_CS-1:0] cs_seen;
    logic              idle_lvl;
    xfer_t             cur;
    bit                have;
    pb = 1'b0; ps = 1'b0; busy_cnt = 0; idle_cnt = 0; edges = 0; last_edge = 0;
    hmin = 0; hmax = 0; sl_tx = '0; sl_rx = '0; cs_seen = '1; idle_lvl = 1'b0; have = 1'b0;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        if (STATUS[0] && !pb) begin
          have = (exp_q.size() != 0);
          check("expected transfer queued", 32'(have), 32'd1);
          if (have) begin
            cur = exp_q[0];
            if (cur.gap >= 0) check("idle cycles between transfers", idle_cnt, cur.gap);
          end
          busy_cnt = 1; edges = 0; last_edge = 0; hmin = 1000000; hmax = 0;
          cs_seen = CS_N; idle_lvl = S_CLK; sl_rx = '0; sl_tx = cur.slv;
          if (!cur.cpha) begin
            MISO = cur.lb ? 1'b0 : sl_tx[DATA_W-1];
            sl_tx = sl_tx << 1;
          end
        end else if (STATUS[0]) begin
          busy_cnt++;
          if (S_CLK !== ps) begin
            edges++;
            if (edges > 1) begin
              if (busy_cnt - last_edge < hmin) hmin = busy_cnt - last_edge;
              if (busy_cnt - last_edge > hmax) hmax = busy_cnt - last_edge;
            end
            last_edge = busy_cnt;
            leading = (S_CLK != cur.cpol);
            if (leading ^ cur.cpha) begin
              sl_rx = {sl_rx[DATA_W-2:0], MOSI};
            end else begin
              MISO = cur.lb ? 1'b0 : sl_tx[DATA_W-1];
              sl_tx = sl_tx << 1;
            end
          end
        end else if (pb) begin
          idle_cnt = 1;
          if (have) begin
            void'(exp_q.pop_front());
            check("rx word", OUTCOMING_DATA, cur.rx);
            check("rx_full after transfer", STATUS[2], 1'b1);
            check("overrun", STATUS[3], cur.ovr);
            check("busy cycles", busy_cnt, (2 * DATA_W + 3) * cur.h);
            check("cs_n during transfer", cs_seen, cur.cs);
            check("mosi word seen by slave", sl_rx, cur.tx);
            check("s_clk min half period", hmin, cur.h);
            check("s_clk max half period", hmax, cur.h);
            check("s_clk edge count", edges, 2 * DATA_W);
            check("s_clk level at start", idle_lvl, cur.cpol);
            check("s_clk level at end", S_CLK, cur.cpol);
            check("cs_n released", CS_N, {NUM_CS{1'b1}});
            have = 1'b0;
          end
        end else begin
          idle_cnt++;
        end
      end
      pb = STATUS[0];
      ps = S_CLK;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [DATA_W-1:0] a, b;
    int n;
    // Reset state while CLR is held low.
    repeat (3) @(negedge CLK);
    check("reset status", STATUS, 4'h0);
    check("reset cs_n", CS_N, {NUM_CS{1'b1}});
    check("reset mosi", MOSI, 1'b0);
    check("reset s_clk", S_CLK, 1'b0);
    check("reset rx data", OUTCOMING_DATA, '0);
    @(negedge CLK);
    CLR = 1'b1;

    // Asynchronous abort in the middle of SHIFT.
    set_cfg(1'b0, 1'b0, 1, 1, 1'b0);
    do_write(8'hFF);
    repeat (8) @(negedge CLK);
    check("abort pre busy", STATUS[0], 1'b1);
    check("abort pre mosi", MOSI, 1'b1);
    #3 CLR = 1'b0;
    #1;
    check("abort cs_n", CS_N, {NUM_CS{1'b1}});
    check("abort status", STATUS, 4'h0);
    check("abort mosi", MOSI, 1'b0);
    check("abort s_clk", S_CLK, 1'b0);
    @(negedge CLK);
    CLR = 1'b1;
    m_rx_full = 1'b0;
    repeat (2) @(negedge CLK);
    mon_en = 1'b1;

    // Mode 0, divider 0, slave 2: A5 out, 3C back.
    set_cfg(1'b0, 1'b0, 0, 2, 1'b0);
    start_xfer(8'hA5, 8'h3C, -1);
    check("tx_full after write", STATUS[1], 1'b1);
    check("busy not yet", STATUS[0], 1'b0);
    @(negedge CLK);
    check("busy after idle edge", STATUS[0], 1'b1);
    check("tx_full cleared on start", STATUS[1], 1'b0);
    check("cs_n select 2", CS_N, 4'b1011);
    wait_done(100);
    do_read();
    @(negedge CLK);
    check("rx_full cleared by read", STATUS[2], 1'b0);

    // Mode 3, divider 3.
    set_cfg(1'b1, 1'b1, 3, 0, 1'b0);
    start_xfer(8'($urandom()), 8'($urandom()), -1);
    wait_done(200);
    do_read();

    // Randomised modes, dividers, selects (including out-of-range) and read habits.
    for (int i = 0; i < 12; i++) begin
      set_cfg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
              $urandom_range(0, 7), 1'($urandom_range(0, 1)));
      start_xfer(8'($urandom()), 8'($urandom()), -1);
      wait_done(300);
      if ($urandom_range(0, 1) == 1) do_read();
    end

    // Back-to-back with a dropped third write and no reads.
    do_read();
    set_cfg(1'b0, 1'b0, 1, 1, 1'b0);
    a = 8'($urandom());
    b = 8'($urandom());
    start_xfer(8'h11, a, -1);
    n = 0;
    while (!STATUS[0] && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("b2b first started", STATUS[0], 1'b1);
    push_xfer(8'h22, b, m_rx_full, 1);
    do_write(8'h22);
    check("b2b second queued", STATUS[1], 1'b1);
    do_write(8'h33);
    wait_done(300);
    repeat (50) @(negedge CLK);
    check("dropped write never starts", STATUS[0], 1'b0);
    check("dropped write never queued", STATUS[1], 1'b0);

    // READ coinciding with HOLD exit while RX is still full: the new word wins.
    set_cfg(1'b0, 1'b0, 0, 3, 1'b0);
    push_xfer(8'($urandom()), 8'($urandom()), 1'b0, -1);
    do_write(exp_q[exp_q.size() - 1].tx);
    repeat ((2 * DATA_W + 2) * (c_div + 1)) @(negedge CLK);
    READ = 1'b1;
    @(negedge CLK);
    READ = 1'b0;
    wait_done(100);
    do_read();
    @(negedge CLK);
    check("rx_full cleared after boundary", STATUS[2], 1'b0);
    check("overrun cleared after boundary", STATUS[3], 1'b0);

    // Loopback request with MISO held low by the slave model when loopback is built in.
    set_cfg(1'b0, 1'b0, 0, 0, 1'b1);
    start_xfer(8'h5A, 8'hC3, -1);
    wait_done(100);
    do_read();

    repeat (5) @(negedge CLK);
    check("scoreboard drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
